// File: rtl/uart_frame_loader.sv
// uart_frame_loader: converts the UART RX byte stream into framebuffer write strobes.
// A full-frame command (CMD_FULL) streams COLS*ROWS bytes from (0,0); a windowed
// command (CMD_WIN) carries a 5-byte header (x, y[15:8], y[7:0], len[15:8], len[7:0])
// followed by len bytes written in raster order with wrap to the top of the frame.
// An idle timeout outside IDLE aborts the command with an err pulse.
module uart_frame_loader #(
    parameter int          COLS     = 128,
    parameter int          ROWS     = 768,
    parameter int          XW       = 7,
    parameter int          YW       = 10,
    parameter logic [7:0]  CMD_FULL = 8'hAA,
    parameter logic [7:0]  CMD_WIN  = 8'hA5,
    parameter int          TIMEOUT  = 6_500_000
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          rx_ready,
    input  logic [7:0]    rx_data,
    output logic          wr_en,
    output logic [XW-1:0] wr_x,
    output logic [YW-1:0] wr_y,
    output logic [7:0]    wr_data,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int NPIX = COLS * ROWS;
    localparam int CW   = ($clog2(NPIX + 1) > 16) ? $clog2(NPIX + 1) : 16;
    localparam int TW   = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_HX, S_HYH, S_HYL, S_HLH, S_HLL, S_DATA
    } state_t;

    state_t          state_q, state_d;
    logic            prev_q;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      hx_q, hx_d, hyh_q, hyh_d, hyl_q, hyl_d, hlh_q, hlh_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            wr_en_q, wr_en_d, done_q, done_d, err_q, err_d, busy_q;
    logic [XW-1:0]   wr_x_q, wr_x_d;
    logic [YW-1:0]   wr_y_q, wr_y_d;
    logic [7:0]      wr_data_q, wr_data_d;

    logic            accept_s;
    logic            tmo_hit_s;
    logic [15:0]     hdr_y_s;
    logic [15:0]     len_s;

    // A byte is accepted on the rising edge of rx_ready.
    assign accept_s  = rx_ready & ~prev_q;
    assign tmo_hit_s = (state_q != S_IDLE) && !accept_s && (32'(tmo_q) == TIMEOUT - 1);
    assign hdr_y_s   = {hyh_q, hyl_q};
    assign len_s     = {hlh_q, rx_data};

    // Next-state, datapath and output strobes.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        cnt_d     = cnt_q;
        hx_d      = hx_q;
        hyh_d     = hyh_q;
        hyl_d     = hyl_q;
        hlh_d     = hlh_q;
        wr_en_d   = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        wr_x_d    = wr_x_q;
        wr_y_d    = wr_y_q;
        wr_data_d = wr_data_q;

        if (accept_s) begin
            case (state_q)
                S_IDLE: begin
                    if (rx_data == CMD_FULL) begin
                        state_d = S_DATA;
                        x_d     = '0;
                        y_d     = '0;
                        cnt_d   = CW'(NPIX);
                    end else if (rx_data == CMD_WIN) begin
                        state_d = S_HX;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_HX:  begin hx_d  = rx_data; state_d = S_HYH; end
                S_HYH: begin hyh_d = rx_data; state_d = S_HYL; end
                S_HYL: begin hyl_d = rx_data; state_d = S_HLH; end
                S_HLH: begin hlh_d = rx_data; state_d = S_HLL; end
                S_HLL: begin
                    if ((32'(hx_q) >= COLS) || (32'(hdr_y_s) >= ROWS) || (len_s == 16'd0)) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        x_d     = XW'(hx_q);
                        y_d     = YW'(hdr_y_s);
                        cnt_d   = CW'(len_s);
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    wr_en_d   = 1'b1;
                    wr_x_d    = x_q;
                    wr_y_d    = y_q;
                    wr_data_d = rx_data;
                    if (32'(x_q) == COLS - 1) begin
                        x_d = '0;
                        if (32'(y_q) == ROWS - 1) begin
                            y_d = '0;
                        end else begin
                            y_d = y_q + YW'(1);
                        end
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (tmo_hit_s) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
        end else begin
            state_d = state_q;
        end

        // Idle timer restarts on every byte and whenever we are (or land) in IDLE.
        if (accept_s || (state_d == S_IDLE)) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    // State, datapath and registered outputs with asynchronous reset.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= S_IDLE;
            prev_q    <= 1'b1;
            x_q       <= '0;
            y_q       <= '0;
            cnt_q     <= '0;
            hx_q      <= 8'h00;
            hyh_q     <= 8'h00;
            hyl_q     <= 8'h00;
            hlh_q     <= 8'h00;
            tmo_q     <= '0;
            wr_en_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            wr_x_q    <= '0;
            wr_y_q    <= '0;
            wr_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            prev_q    <= rx_ready;
            x_q       <= x_d;
            y_q       <= y_d;
            cnt_q     <= cnt_d;
            hx_q      <= hx_d;
            hyh_q     <= hyh_d;
            hyl_q     <= hyl_d;
            hlh_q     <= hlh_d;
            tmo_q     <= tmo_d;
            wr_en_q   <= wr_en_d;
            done_q    <= done_d;
            err_q     <= err_d;
            busy_q    <= (state_d != S_IDLE);
            wr_x_q    <= wr_x_d;
            wr_y_q    <= wr_y_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_x    = wr_x_q;
    assign wr_y    = wr_y_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Scoreboard bench for uart_frame_loader (COLS=4, ROWS=3, TIMEOUT=50).
module tb_uart_frame_loader;

    localparam int COLS = 4;
    localparam int ROWS = 3;
    localparam int XW   = 2;
    localparam int YW   = 2;
    localparam int TMO  = 50;

    logic          sys_clk;
    logic          sys_rst;
    logic          rx_ready;
    logic [7:0]    rx_data;
    logic          wr_en;
    logic [XW-1:0] wr_x;
    logic [YW-1:0] wr_y;
    logic [7:0]    wr_data;
    logic          busy;
    logic          done;
    logic          err;

    uart_frame_loader #(
        .COLS(COLS), .ROWS(ROWS), .XW(XW), .YW(YW),
        .CMD_FULL(8'hAA), .CMD_WIN(8'hA5), .TIMEOUT(TMO)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .rx_ready(rx_ready), .rx_data(rx_data),
        .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
        .busy(busy), .done(done), .err(err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic          is_err;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [7:0]    d;
        logic          dn;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   err_cnt  = 0;
    int   last_wr_cyc  = 0;
    int   last_err_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    task automatic push_wr(input int x, input int y, input logic [7:0] d, input logic dn);
        exp_t e;
        e.is_err = 1'b0;
        e.x      = XW'(x);
        e.y      = YW'(y);
        e.d      = d;
        e.dn     = dn;
        exp_q.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e = '0;
        e.is_err = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge sys_clk); #1;
        rx_data  = b;
        rx_ready = 1'b1;
        @(posedge sys_clk);
        @(posedge sys_clk); #1;
        rx_ready = 1'b0;
        @(posedge sys_clk);
        @(posedge sys_clk);
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge sys_clk);
    endtask

    // Waits (bounded) for the next err pulse seen by the monitor.
    task automatic wait_err(input string name, input int prev);
        int n;
        n = 0;
        while (err_cnt == prev && n < 150) begin
            @(posedge sys_clk);
            n++;
        end
        check(name, 32'(err_cnt != prev), 32'd1);
    endtask

    // Monitor: pops one expectation for every write or err event.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge sys_clk);
            cyc++;
            if (!sys_rst) begin
                if (done && !wr_en) begin
                    check("stray_done", 32'(done), 32'd0);
                end
                if (wr_en || err) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_event", {30'd0, wr_en, err}, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("event_kind", {30'd0, wr_en, err}, e.is_err ? 32'd1 : 32'd2);
                        if (!e.is_err) begin
                            check("wr_x", 32'(wr_x), 32'(e.x));
                            check("wr_y", 32'(wr_y), 32'(e.y));
                            check("wr_data", 32'(wr_data), 32'(e.d));
                            check("done", 32'(done), 32'(e.dn));
                        end
                    end
                    if (wr_en) last_wr_cyc = cyc;
                    if (err) begin
                        last_err_cyc = cyc;
                        err_cnt++;
                    end
                end
            end
        end
    endtask

    initial begin
        int prev;
        sys_rst  = 1'b1;
        rx_ready = 1'b0;
        rx_data  = 8'h00;
        fork
            monitor();
        join_none
        wait_cycles(3);
        @(negedge sys_clk);
        check("reset_outputs", {18'd0, wr_en, wr_x, wr_y, wr_data, busy, done, err}, 32'd0);
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        wait_cycles(2);

        // 1. Full frame; a leading junk byte is dropped.
        for (int i = 0; i < 12; i++) push_wr(i % 4, i / 4, 8'(i), (i == 11));
        send_byte(8'h55);
        @(negedge sys_clk);
        check("junk_not_busy", 32'(busy), 32'd0);
        send_byte(8'hAA);
        for (int i = 0; i < 12; i++) send_byte(8'(i));
        @(negedge sys_clk);
        check("full_busy_after", 32'(busy), 32'd0);

        // 2. Windowed load wrapping from the last pixel to (0,0).
        push_wr(2, 2, 8'hD0, 1'b0);
        push_wr(3, 2, 8'hD1, 1'b0);
        push_wr(0, 0, 8'hD2, 1'b0);
        push_wr(1, 0, 8'hD3, 1'b1);
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h04);
        @(negedge sys_clk);
        check("win_busy_hdr", 32'(busy), 32'd1);
        send_byte(8'hD0); send_byte(8'hD1); send_byte(8'hD2); send_byte(8'hD3);
        @(negedge sys_clk);
        check("win_busy_after", 32'(busy), 32'd0);

        // 4. len == 0 is rejected.
        push_err();
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        @(negedge sys_clk);
        check("len0_idle", 32'(busy), 32'd0);

        // 3. x out of range, then a new AA is accepted (and left to time out).
        push_err();
        send_byte(8'hA5); send_byte(8'h04); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        @(negedge sys_clk);
        check("badhdr_idle", 32'(busy), 32'd0);
        send_byte(8'hAA);
        @(negedge sys_clk);
        check("aa_after_err_busy", 32'(busy), 32'd1);
        push_err();
        wait_err("badhdr_aa_timeout", err_cnt);

        // 5. Timeout after three pixels.
        push_wr(0, 0, 8'h11, 1'b0);
        push_wr(1, 0, 8'h22, 1'b0);
        push_wr(2, 0, 8'h33, 1'b0);
        push_err();
        prev = err_cnt;
        send_byte(8'hAA); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        wait_err("timeout_err", prev);
        check("timeout_delay", 32'(last_err_cyc - last_wr_cyc), 32'd50);
        @(negedge sys_clk);
        check("timeout_idle", 32'(busy), 32'd0);
        push_wr(0, 0, 8'h44, 1'b0);
        send_byte(8'hAA); send_byte(8'h44);

        // 6. Reset during DATA with rx_ready rising together with reset.
        @(posedge sys_clk); #1;
        sys_rst  = 1'b1;
        rx_ready = 1'b1;
        rx_data  = 8'h77;
        wait_cycles(2);
        @(negedge sys_clk);
        check("midrst_outputs", {18'd0, wr_en, wr_x, wr_y, wr_data, busy, done, err}, 32'd0);
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        wait_cycles(10);
        @(negedge sys_clk);
        check("held_high_idle", 32'(busy), 32'd0);
        #1;
        rx_ready = 1'b0;
        wait_cycles(2);
        push_wr(0, 0, 8'h99, 1'b0);
        send_byte(8'hAA); send_byte(8'h99);
        wait_cycles(3);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
